// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator and the decode controller:
// next-PC op codes, default vectors and op classification.
package pc_gen_pkg;

  localparam int NPC_OP_W = 3;

  localparam logic [NPC_OP_W-1:0] NPC_SEQ    = 3'd0;
  localparam logic [NPC_OP_W-1:0] NPC_OFFSET = 3'd1;
  localparam logic [NPC_OP_W-1:0] NPC_JUMP   = 3'd2;
  localparam logic [NPC_OP_W-1:0] NPC_JREG   = 3'd3;
  localparam logic [NPC_OP_W-1:0] NPC_CALL   = 3'd4;
  localparam logic [NPC_OP_W-1:0] NPC_CALLR  = 3'd5;
  localparam logic [NPC_OP_W-1:0] NPC_RET    = 3'd6;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    TGT_NONE   = 2'd0,
    TGT_OFFSET = 2'd1,
    TGT_JUMP   = 2'd2,
    TGT_REG    = 2'd3
  } tgt_kind_e;

  // SEQ and the reserved code both fall through to TGT_NONE (no redirect).
  function automatic tgt_kind_e op_kind(input logic [NPC_OP_W-1:0] op);
    tgt_kind_e k;
    case (op)
      NPC_OFFSET:                    k = TGT_OFFSET;
      NPC_JUMP, NPC_CALL:            k = TGT_JUMP;
      NPC_JREG, NPC_CALLR, NPC_RET:  k = TGT_REG;
      default:                       k = TGT_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Decode-to-fetch control-flow bus: one redirect request with its operands.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                redirect_i;
  logic [NPC_OP_W-1:0] npc_op_i;
  logic [WIDTH-1:0]    id_pc_i;
  logic [15:0]         imm16_i;
  logic [25:0]         imm26_i;
  logic [WIDTH-1:0]    rs_data_i;

  modport master (
    output redirect_i, npc_op_i, id_pc_i, imm16_i, imm26_i, rs_data_i
  );

  modport slave (
    input redirect_i, npc_op_i, id_pc_i, imm16_i, imm26_i, rs_data_i
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty does nothing.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             valid
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx_s;

  // ptr_q is the next write slot; wrapping it onto the oldest slot gives the overwrite.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && (cnt_q != CNT_W'(0))) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_comb begin
    top_idx_s = ptr_q - PTR_W'(1);
    valid     = (cnt_q != CNT_W'(0));
    if (valid) begin
      top = mem_q[top_idx_s];
    end else begin
      top = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: next-PC arithmetic, stall-proof redirect buffering,
// return-address stack and saturating redirect/RAS-hit statistics.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(DEF_EXC_VECTOR),
  parameter int               RAS_DEPTH   = 4,
  parameter int               LINK_OFFSET = 4,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 exc_i,
  pc_gen_if.slave              dec_if,
  output logic [WIDTH-1:0]     pc_o,
  output logic [WIDTH-1:0]     ras_top_o,
  output logic                 ras_valid_o,
  output logic                 misalign_o,
  output logic [CNT_WIDTH-1:0] redirect_cnt_o,
  output logic [CNT_WIDTH-1:0] ras_hit_cnt_o
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      return v + CNT_WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  tgt_kind_e        kind_s;
  logic [WIDTH-1:0] p4_s, link_s, target_s;
  logic             valid_redir_s, misalign_s, accept_s, push_s, pop_s, hit_s;

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]     pend_tgt_q, pend_tgt_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_WIDTH-1:0] ras_hit_cnt_q, ras_hit_cnt_d;

  // Target decode; a misaligned register target is rejected before any side effect.
  always_comb begin
    kind_s = op_kind(dec_if.npc_op_i);
    p4_s   = dec_if.id_pc_i + WIDTH'(4);
    link_s = dec_if.id_pc_i + WIDTH'(LINK_OFFSET);
    case (kind_s)
      TGT_OFFSET: target_s = p4_s + {{(WIDTH-18){dec_if.imm16_i[15]}}, dec_if.imm16_i, 2'b00};
      TGT_JUMP:   target_s = {p4_s[WIDTH-1:28], dec_if.imm26_i, 2'b00};
      TGT_REG:    target_s = dec_if.rs_data_i;
      default:    target_s = p4_s;
    endcase
    valid_redir_s = dec_if.redirect_i && (kind_s != TGT_NONE);
    misalign_s    = valid_redir_s && (kind_s == TGT_REG) && (dec_if.rs_data_i[1:0] != 2'b00);
    accept_s      = valid_redir_s && !misalign_s;
    push_s        = accept_s && ((dec_if.npc_op_i == NPC_CALL) || (dec_if.npc_op_i == NPC_CALLR));
    pop_s         = accept_s && (dec_if.npc_op_i == NPC_RET);
    hit_s         = pop_s && ras_valid_o && (ras_top_o == dec_if.rs_data_i);
  end

  // Next-PC priority: exception, misalignment, stall, live redirect, pending, sequential.
  always_comb begin
    pc_d       = pc_q + WIDTH'(4);
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_i) begin
      pc_d       = EXC_VECTOR;
      pend_vld_d = 1'b0;
    end else if (misalign_s) begin
      pc_d       = EXC_VECTOR;
      pend_vld_d = 1'b0;
    end else if (stall_i) begin
      pc_d = pc_q;
      if (accept_s) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = target_s;
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end else if (accept_s) begin
      pc_d       = target_s;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      pc_d       = pend_tgt_q;
      pend_vld_d = 1'b0;
    end else begin
      pc_d = pc_q + WIDTH'(4);
    end
    misalign_d     = misalign_s;
    redirect_cnt_d = sat_inc(redirect_cnt_q, accept_s);
    ras_hit_cnt_d  = sat_inc(ras_hit_cnt_q, hit_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      pend_vld_q     <= 1'b0;
      pend_tgt_q     <= '0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= '0;
      ras_hit_cnt_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      pend_vld_q     <= pend_vld_d;
      pend_tgt_q     <= pend_tgt_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
      ras_hit_cnt_q  <= ras_hit_cnt_d;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (link_s),
    .top       (ras_top_o),
    .valid     (ras_valid_o)
  );

  assign pc_o           = pc_q;
  assign misalign_o     = misalign_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign ras_hit_cnt_o  = ras_hit_cnt_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program-counter generator: owns the PC register, resolves all next-PC arithmetic (sequential, PC-relative branch, absolute jump, register jump), and keeps a small return-address stack (RAS) with hit statistics. Redirects come from the decode stage and are buffered across fetch stalls, so none is lost. It replaces the purely combinational next-PC adder and sits between the decode control path and the instruction-memory address port.

## Interface
- `WIDTH`, 32: address width; must be ≥ 28 + 2.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `EXC_VECTOR`, 32'h0000_4180: PC loaded on exception or misaligned register target.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, ≥ 2.
- `LINK_OFFSET`, 4: link address = `id_pc_i` + `LINK_OFFSET`.
- `CNT_WIDTH`, 16: statistic counter width.

Ports:
- `clk` in 1: clock, rising edge. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in 1: hold the PC.
- `exc_i` in 1: exception flush. Highest priority.
- `redirect_i` in 1: decode presents a control-flow op. One-cycle pulse per instruction.
- `npc_op_i` in 3: op code, from `pc_gen_pkg`.
- `id_pc_i` in WIDTH: PC of the decoding instruction.
- `imm16_i` in 16: branch offset in words.
- `imm26_i` in 26: jump index.
- `rs_data_i` in WIDTH: register target.
- `pc_o` out WIDTH: current fetch PC, registered.
- `ras_top_o` out WIDTH: RAS top entry; 0 when empty.
- `ras_valid_o` out 1: RAS non-empty.
- `misalign_o` out 1: registered pulse for a misaligned register target.
- `redirect_cnt_o` out CNT_WIDTH: accepted redirects, saturating.
- `ras_hit_cnt_o` out CNT_WIDTH: RET ops whose RAS top equalled `rs_data_i`, saturating.

## Operation
- Op codes: SEQ=0, OFFSET=1, JUMP=2, JREG=3, CALL=4, CALLR=5, RET=6, 7 reserved (treated as SEQ).
- Target computation, with p4 = `id_pc_i` + 4:
  - OFFSET → p4 + sext(imm16)<<2. Wraps modulo 2^WIDTH.
  - JUMP/CALL → {p4[WIDTH-1:28], imm26, 2'b00}.
  - JREG/CALLR/RET → `rs_data_i`.
- CALL/CALLR push `id_pc_i`+`LINK_OFFSET`. RET pops.
- RAS behaviour:
  - Circular buffer with a count.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty is a no-op.
- On RET with RAS non-empty and top == `rs_data_i`, `ras_hit_cnt_o` increments. The comparison uses the top before the pop.
- Misalignment: a register-class op with target[1:0] ≠ 0 sets `misalign_o`=1 next cycle and loads `EXC_VECTOR`. For that op:
  - no RAS update;
  - no redirect count.
- Pending buffer: a one-entry register {valid, target}.
  - A redirect accepted while `stall_i`=1 is stored; a newer one overwrites it.
  - RAS and counter updates happen at acceptance, not at application.
- Next-PC priority each cycle:
  1. `exc_i` → `EXC_VECTOR`; clears pending; ignores stall.
  2. Misaligned redirect → `EXC_VECTOR`.
  3. `stall_i` → hold.
  4. `redirect_i` (valid, non-SEQ) → target.
  5. Pending valid → pending target; clear pending.
  6. Otherwise → `pc_o`+4.
- SEQ with `redirect_i` does not count as a redirect.
- Counters saturate at all-ones.

## Timing
- Reset values:
  - `pc_o`=RESET_PC;
  - pending cleared; RAS empty; `ras_top_o`=0; `ras_valid_o`=0;
  - `misalign_o`=0; both counters 0.
- Redirect at cycle t with no stall → `pc_o`=target at t+1.
- Redirect at t with `stall_i` high until u-1 and low at u → `pc_o`=target at u+1.
- Redirect together with `exc_i` → exception wins. RAS and counter side effects of that redirect still occur.
- RAS and `ras_valid_o` update at the edge after acceptance.
- Reset asserted mid-operation clears everything asynchronously. The first post-reset `pc_o` is RESET_PC.

## Structure
- `pc_gen_pkg`: holds the op-code localparams, `NPC_OP_W`=3, and the default vectors. It is shared with the decode controller.
- One sub-module, `ras_stack`, with parameters (WIDTH, RAS_DEPTH) and signals push, pop, push_data, top, valid.
- Target arithmetic, pending register, priority mux and counters live in `pc_gen`.

## Test plan
- Reset, then 3 idle cycles → `pc_o` = 3000, 3004, 3008, 300C.
- OFFSET, `id_pc_i`=3010, imm16=FFFE → `pc_o`=300C next cycle; `redirect_cnt_o`=1.
- CALL at id_pc 3020, imm26=0000400, then RET with rs=3024 → `pc_o`=1000, then 3024; `ras_hit_cnt_o`=1; `ras_valid_o`=0.
- Five CALLs (link A..E) with RAS_DEPTH=4, then five RETs matching E..A:
  - 4 hits;
  - the fifth RET sees an empty RAS, so the hit count stays 4.
- JUMP with `stall_i` high for 3 cycles → PC holds; target appears the cycle after stall drops; count increments once.
- JREG rs=3002 → `misalign_o` pulse, `pc_o`=4180, no count. Then `exc_i` together with a pending redirect → `pc_o`=4180, pending discarded.
